// File: rtl/cp0_exc_ctrl.sv
// Coprocessor-0 exception/interrupt controller: takes interrupts and exceptions
// at the M stage, keeps SR/Cause/EPC, and serves mfc0/mtc0/eret.
module cp0_exc_ctrl #(
  parameter logic [31:0] PRID = 32'h2021_0707
) (
  input  logic        clk,
  input  logic        reset,
  input  logic [4:0]  A1,
  input  logic [4:0]  A2,
  input  logic [31:0] DIn,
  input  logic        WE,
  input  logic [31:0] PC,
  input  logic        BDIn,
  input  logic [4:0]  ExcCodeIn,
  input  logic [5:0]  HWInt,
  input  logic        EXLClr,
  output logic [31:0] DOut,
  output logic [31:0] EPCOut,
  output logic        Req
);

  localparam logic [4:0] REG_SR    = 5'd12;
  localparam logic [4:0] REG_CAUSE = 5'd13;
  localparam logic [4:0] REG_EPC   = 5'd14;
  localparam logic [4:0] REG_PRID  = 5'd15;

  logic [5:0]  im_q, im_d;
  logic        exl_q, exl_d;
  logic        ie_q, ie_d;
  logic        bd_q, bd_d;
  logic [5:0]  ip_q, ip_d;
  logic [4:0]  exc_code_q, exc_code_d;
  logic [31:0] epc_q, epc_d;

  logic        int_req;
  logic        exc_req;
  logic [31:0] sr_word;
  logic [31:0] cause_word;

  // Interrupts look at the live HWInt lines, not the latched IP field.
  always_comb begin
    int_req = ie_q & ~exl_q & (|(HWInt & im_q));
    exc_req = ~exl_q & (ExcCodeIn != 5'd0);
    Req     = ~reset & (int_req | exc_req);
  end

  always_comb begin
    im_d       = im_q;
    exl_d      = exl_q;
    ie_d       = ie_q;
    bd_d       = bd_q;
    ip_d       = HWInt;
    exc_code_d = exc_code_q;
    epc_d      = epc_q;
    if (Req) begin
      exl_d      = 1'b1;
      exc_code_d = int_req ? 5'd0 : ExcCodeIn;
      bd_d       = BDIn;
      epc_d      = BDIn ? (PC - 32'd4) : PC;
    end else begin
      if (WE && (A2 == REG_SR)) begin
        im_d  = DIn[15:10];
        exl_d = DIn[1];
        ie_d  = DIn[0];
      end
      if (WE && (A2 == REG_EPC)) begin
        epc_d = DIn;
      end
      // eret wins over a same-cycle SR write for the EXL bit only.
      if (EXLClr) begin
        exl_d = 1'b0;
      end
    end
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      im_q       <= 6'd0;
      exl_q      <= 1'b0;
      ie_q       <= 1'b0;
      bd_q       <= 1'b0;
      ip_q       <= 6'd0;
      exc_code_q <= 5'd0;
      epc_q      <= 32'd0;
    end else begin
      im_q       <= im_d;
      exl_q      <= exl_d;
      ie_q       <= ie_d;
      bd_q       <= bd_d;
      ip_q       <= ip_d;
      exc_code_q <= exc_code_d;
      epc_q      <= epc_d;
    end
  end

  always_comb begin
    sr_word    = {16'd0, im_q, 8'd0, exl_q, ie_q};
    cause_word = {bd_q, 15'd0, ip_q, 3'd0, exc_code_q, 2'd0};
    unique case (A1)
      REG_SR:    DOut = sr_word;
      REG_CAUSE: DOut = cause_word;
      REG_EPC:   DOut = epc_q;
      REG_PRID:  DOut = PRID;
      default:   DOut = 32'd0;
    endcase
    EPCOut = epc_q;
  end

endmodule

// File: tb/tb_cp0_exc_ctrl.sv
// Bench for cp0_exc_ctrl: word-level register model checked every cycle,
// plus directed scenarios with hand-computed literal expectations.
module tb_cp0_exc_ctrl;

  localparam logic [31:0] PRID = 32'h2021_0707;

  logic        clk = 1'b0;
  logic        reset;
  logic [4:0]  A1, A2;
  logic [31:0] DIn;
  logic        WE;
  logic [31:0] PC;
  logic        BDIn;
  logic [4:0]  ExcCodeIn;
  logic [5:0]  HWInt;
  logic        EXLClr;
  logic [31:0] DOut, EPCOut;
  logic        Req;

  int total = 0;
  int bad   = 0;
  bit chk_en = 1'b0;

  // Model architectural registers as whole 32-bit words.
  logic [31:0] m_sr, m_cause, m_epc;

  cp0_exc_ctrl #(.PRID(PRID)) dut (
    .clk(clk), .reset(reset), .A1(A1), .A2(A2), .DIn(DIn), .WE(WE),
    .PC(PC), .BDIn(BDIn), .ExcCodeIn(ExcCodeIn), .HWInt(HWInt),
    .EXLClr(EXLClr), .DOut(DOut), .EPCOut(EPCOut), .Req(Req)
  );

  always #5 clk = ~clk;

  function automatic bit m_int();
    return m_sr[0] && !m_sr[1] && ((HWInt & m_sr[15:10]) != 6'd0);
  endfunction

  function automatic bit m_req();
    return !reset && (m_int() || (!m_sr[1] && ExcCodeIn != 5'd0));
  endfunction

  function automatic logic [31:0] m_read(input logic [4:0] a);
    case (a)
      5'd12:   return m_sr;
      5'd13:   return m_cause;
      5'd14:   return m_epc;
      5'd15:   return PRID;
      default: return 32'd0;
    endcase
  endfunction

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    total++;
    if (act !== exp) begin
      bad++;
      $display("FAIL %s: got %h expected %h at %0t", name, act, exp, $time);
    end
  endtask

  always @(posedge clk) begin
    if (reset) begin
      m_sr = 32'd0; m_cause = 32'd0; m_epc = 32'd0;
    end else if (m_req()) begin
      m_cause = ({31'd0, BDIn} << 31) | ({26'd0, HWInt} << 10)
              | ({27'd0, (m_int() ? 5'd0 : ExcCodeIn)} << 2);
      m_sr    = m_sr | 32'h2;
      m_epc   = PC - (BDIn ? 32'd4 : 32'd0);
    end else begin
      m_cause = (m_cause & ~32'h0000_FC00) | ({26'd0, HWInt} << 10);
      if (WE && A2 == 5'd12) m_sr = DIn & 32'h0000_FC03;
      if (WE && A2 == 5'd14) m_epc = DIn;
      if (EXLClr) m_sr = m_sr & ~32'h2;
    end
  end

  always @(negedge clk) begin
    if (chk_en) begin
      chk("model_req", {31'd0, Req}, {31'd0, m_req()});
      chk("model_dout", DOut, m_read(A1));
      chk("model_epcout", EPCOut, m_epc);
    end
  end

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  initial begin
    reset = 1'b1; A1 = 5'd12; A2 = 5'd0; DIn = 32'd0; WE = 1'b0;
    PC = 32'd0; BDIn = 1'b0; ExcCodeIn = 5'd0; HWInt = 6'd0; EXLClr = 1'b0;
    tick();
    chk_en = 1'b1;
    @(negedge clk);
    chk("reset_req", {31'd0, Req}, 32'd0);
    chk("reset_sr", DOut, 32'd0);

    // Interrupt path
    tick();
    reset = 1'b0; WE = 1'b1; A2 = 5'd12; DIn = 32'h0000_0401;
    tick();
    WE = 1'b0; HWInt = 6'b000001; PC = 32'h0000_1000;
    @(negedge clk);
    chk("int_req", {31'd0, Req}, 32'd1);
    tick();
    A1 = 5'd13;
    @(negedge clk);
    chk("int_cause", DOut, 32'h0000_0400);
    chk("int_req_masked", {31'd0, Req}, 32'd0);
    chk("int_epc", EPCOut, 32'h0000_1000);
    A1 = 5'd12;
    #1 chk("int_sr", DOut, 32'h0000_0403);
    tick();
    WE = 1'b1; A2 = 5'd12; DIn = 32'd0; HWInt = 6'd0;
    tick();

    // Overflow in a delay slot, with a colliding EPC write
    WE = 1'b1; A2 = 5'd14; DIn = 32'hDEAD_BEEC;
    ExcCodeIn = 5'd12; PC = 32'h0000_3010; BDIn = 1'b1;
    @(negedge clk);
    chk("ov_req", {31'd0, Req}, 32'd1);
    tick();
    WE = 1'b0; ExcCodeIn = 5'd0; BDIn = 1'b0; A1 = 5'd13;
    @(negedge clk);
    chk("ov_cause", DOut, 32'h8000_0030);
    chk("ov_epc", EPCOut, 32'h0000_300C);

    // Masked while EXL, then eret releases it
    ExcCodeIn = 5'd4;
    #1 chk("exl_mask_req", {31'd0, Req}, 32'd0);
    tick();
    EXLClr = 1'b1;
    @(negedge clk);
    chk("exl_cause_hold", DOut, 32'h8000_0030);
    tick();
    EXLClr = 1'b0; A1 = 5'd12;
    @(negedge clk);
    chk("eret_req", {31'd0, Req}, 32'd1);
    chk("eret_sr", DOut, 32'd0);
    tick();
    ExcCodeIn = 5'd0; A1 = 5'd13;
    @(negedge clk);
    chk("adel_cause", DOut, 32'h0000_0010);
    chk("adel_epc", EPCOut, 32'h0000_3010);

    // mtc0 to Cause ignored; EPC write, no bypass
    tick();
    WE = 1'b1; A2 = 5'd13; DIn = 32'hFFFF_FFFF;
    tick();
    A2 = 5'd14; DIn = 32'h1234_5678;
    @(negedge clk);
    chk("cause_wr_ignored", DOut, 32'h0000_0010);
    A1 = 5'd14;
    #1 chk("epc_old", DOut, 32'h0000_3010);
    tick();
    WE = 1'b0;
    @(negedge clk);
    chk("epc_new", DOut, 32'h1234_5678);
    chk("epcout_new", EPCOut, 32'h1234_5678);
    A1 = 5'd15;
    #1 chk("prid", DOut, 32'h2021_0707);
    A1 = 5'd3;
    #1 chk("unused_reg", DOut, 32'd0);

    // Reset mid-operation with EXL=1 and AdES pending
    tick();
    reset = 1'b1; ExcCodeIn = 5'd5;
    @(negedge clk);
    chk("rst_req", {31'd0, Req}, 32'd0);
    tick();
    reset = 1'b0; A1 = 5'd12;
    @(negedge clk);
    chk("post_rst_req", {31'd0, Req}, 32'd1);
    chk("post_rst_sr", DOut, 32'd0);
    chk("post_rst_epc", EPCOut, 32'd0);
    tick();

    // Interrupt beats a simultaneous RI; eret via SR write
    ExcCodeIn = 5'd0; WE = 1'b1; A2 = 5'd12; DIn = 32'h0000_0801;
    tick();
    WE = 1'b0; HWInt = 6'b000010; ExcCodeIn = 5'd10; PC = 32'h0000_2000;
    @(negedge clk);
    chk("prio_req", {31'd0, Req}, 32'd1);
    tick();
    ExcCodeIn = 5'd0; A1 = 5'd13;
    @(negedge clk);
    chk("prio_cause", DOut, 32'h0000_0800);
    tick();
    tick();

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule

// File: doc/cp0_exc_ctrl.md
Name: cp0_exc_ctrl

Overview:
- Coprocessor-0 exception/interrupt controller for the 5-stage MIPS CPU.
- Sits at the M stage and is the consumer of the exception codes from E-stage arithmetic overflow and address-error detection, plus F/D-stage codes.
- Decides whether an exception or interrupt is taken, saves EPC, Cause and SR state, and serves mfc0/mtc0/eret.

Parameters:
- PRID, 32'h2021_0707, constant value returned for PRId (reg 15).

Ports:
- clk  input  1  system clock; all state updates on the rising edge
- reset  input  1  synchronous, active-high reset
- A1  input  5  mfc0 read register number
- A2  input  5  mtc0 write register number
- DIn  input  32  mtc0 write data
- WE  input  1  mtc0 write enable
- PC  input  32  PC of the M-stage instruction
- BDIn  input  1  M-stage instruction is in a branch delay slot
- ExcCodeIn  input  5  pending exception code of the M-stage instruction; 0 = none
- HWInt  input  6  external hardware interrupt lines
- EXLClr  input  1  eret in M stage
- DOut  output  32  mfc0 read data
- EPCOut  output  32  current EPC register value, used as the eret target
- Req  output  1  exception/interrupt taken this cycle; flushes the pipeline and redirects the PC to the handler

Behaviour:
- Registers and field layout:
  - SR(12): IM[15:10], EXL[1], IE[0]; all other bits read 0.
  - Cause(13): BD[31], IP[15:10], ExcCode[6:2]; all other bits read 0.
  - EPC(14): 32 bits, full width.
  - PRId(15): reads PRID.
  - Any other A1 reads 0.
- Reset (reset=1 at the edge): SR=0, Cause=0, EPC=0.
- During a cycle with reset asserted: Req=0. DOut and EPCOut reflect register contents, so they read 0 from the cycle after reset.
- Request logic, combinational in the same cycle:
  - IntReq = IE & ~EXL & |(HWInt & IM).
  - ExcReq = ~EXL & (ExcCodeIn != 0).
  - Req = ~reset & (IntReq | ExcReq).
  - Interrupt has priority over exception when both are present.
- On a clock edge with Req=1:
  - EXL<=1.
  - Cause.ExcCode <= IntReq ? 0 : ExcCodeIn.
  - Cause.BD <= BDIn.
  - EPC <= BDIn ? PC-4 : PC, with 32-bit wrap. EPC is not aligned; an AdEL on a misaligned PC stores the misaligned value.
- Exception codes in use: Int=0, AdEL=4, AdES=5, RI=10, Ov=12. The block does not filter codes; it latches any nonzero value.
- Cause.IP <= HWInt on every non-reset edge, regardless of Req or EXL.
- mtc0 (WE=1, Req=0):
  - A2=12 writes IM, EXL and IE from DIn.
  - A2=14 writes EPC <= DIn.
  - Writes to Cause, PRId or other registers are ignored.
- Same-cycle conflicts:
  - WE together with Req: the write is discarded and Req's updates win.
  - WE to SR together with EXLClr: the DIn fields are applied, then EXL is forced to 0.
- EXLClr=1 with Req=0: EXL<=0 on the edge. Req cannot fire while EXL=1, so eret and a taken exception never collide.
- mfc0 read: DOut is combinational from A1 and the current registers. A write in the same cycle is visible only from the next cycle (no bypass).
- EPCOut is combinational from the EPC register; it shows the updated value one cycle after Req or mtc0.
- Latency:
  - Req is asserted in the same cycle as its cause.
  - State updates are visible one cycle later.
  - Interrupts use live HWInt, not the registered IP.
- Nested requests: while EXL=1, all exceptions and interrupts are masked and ExcCodeIn is ignored. Pending HWInt re-asserts Req in the first cycle after EXL clears, provided IE and IM still allow it.
- Reset mid-operation: all state returns to the reset values and Req is forced 0 even if ExcCodeIn!=0.
- Expected implementation size: about 150 lines.

Test Plan:
- Reset, then mtc0 SR=32'h0000_0401, set HWInt=6'b000001 -> Req=1 the same cycle. Next cycle: Cause=32'h0000_0400, EXL=1, EPC=PC, Req=0 while HWInt stays high.
- ExcCodeIn=12 (Ov), PC=32'h0000_3010, BDIn=1, IE=0 -> Req=1 and Cause.ExcCode=12. Next cycle: EPC=32'h0000_300C, Cause[31]=1, DOut(A1=13)=32'h8000_0030.
- Same cycle as the above exception, WE=1, A2=14, DIn=32'hDEAD_BEEC -> EPC=32'h0000_300C; the write is discarded.
- EXL=1 with ExcCodeIn=4 -> Req=0 and no state change. Pulse EXLClr -> EXL=0 next cycle. ExcCodeIn=4 still present -> Req=1 in that cycle.
- mtc0 A2=13 DIn=32'hFFFF_FFFF -> Cause unchanged. mtc0 A2=14 DIn=32'h1234_5678 -> DOut(A1=14) is the old value that cycle and 32'h1234_5678 the next cycle; EPCOut matches. A1=15 reads 32'h2021_0707, A1=3 reads 0.
- Assert reset while EXL=1 and ExcCodeIn=5 -> Req=0 during reset. From the next cycle SR, Cause and EPC read 0, and Req=1 if ExcCodeIn is still 5.
